// File: rtl/crossing_controller.sv
// rtl/crossing_controller.sv - pedestrian crossing sequencer (main-road and walk lamps)
// Tick-timed six-state sequence; all lamp outputs registered from the next state.
module crossing_controller #(
  parameter int T_GREEN_MIN = 6,
  parameter int T_YELLOW    = 2,
  parameter int T_ALLRED    = 1,
  parameter int T_WALK      = 5,
  parameter int T_FLASH     = 4,
  parameter int CNT_W       = 4
) (
  input  logic       clk,
  input  logic       sys_reset,
  input  logic       tick,
  input  logic       walkRegister_status,
  output logic       walkRegister_reset,
  output logic [2:0] main_light,
  output logic       walk_light,
  output logic       dont_walk_light,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALL_RED1    = 3'd2,
    WALK        = 3'd3,
    WALK_FLASH  = 3'd4,
    ALL_RED2    = 3'd5
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_next;
  logic [2:0]       main_next;
  logic             walk_next;
  logic             dont_walk_next;
  logic             clr_next;

  function automatic logic [CNT_W-1:0] load_val(input state_t s);
    logic [CNT_W-1:0] v;
    case (s)
      MAIN_GREEN:  v = CNT_W'(T_GREEN_MIN - 1);
      MAIN_YELLOW: v = CNT_W'(T_YELLOW - 1);
      ALL_RED1:    v = CNT_W'(T_ALLRED - 1);
      WALK:        v = CNT_W'(T_WALK - 1);
      WALK_FLASH:  v = CNT_W'(T_FLASH - 1);
      ALL_RED2:    v = CNT_W'(T_ALLRED - 1);
      default:     v = CNT_W'(T_GREEN_MIN - 1);
    endcase
    return v;
  endfunction

  function automatic state_t succ(input state_t s);
    state_t n;
    case (s)
      MAIN_GREEN:  n = MAIN_YELLOW;
      MAIN_YELLOW: n = ALL_RED1;
      ALL_RED1:    n = WALK;
      WALK:        n = WALK_FLASH;
      WALK_FLASH:  n = ALL_RED2;
      default:     n = MAIN_GREEN;
    endcase
    return n;
  endfunction

  always_comb begin
    state_next = state;
    timer_next = timer;
    case (state)
      MAIN_GREEN, MAIN_YELLOW, ALL_RED1, WALK, WALK_FLASH, ALL_RED2: begin
        if (tick) begin
          if (timer != '0) begin
            timer_next = timer - CNT_W'(1);
          end else if (state != MAIN_GREEN || walkRegister_status) begin
            state_next = succ(state);
            timer_next = load_val(succ(state));
          end
          // green with no request: timer parks at 0 so the next request exits on its tick
        end
      end
      default: begin
        state_next = MAIN_GREEN;
        timer_next = load_val(MAIN_GREEN);
      end
    endcase
  end

  always_comb begin
    main_next      = 3'b100;
    walk_next      = 1'b0;
    dont_walk_next = 1'b1;
    clr_next       = 1'b0;
    case (state_next)
      MAIN_GREEN:  main_next = 3'b001;
      MAIN_YELLOW: main_next = 3'b010;
      ALL_RED1:    main_next = 3'b100;
      WALK: begin
        walk_next      = 1'b1;
        dont_walk_next = 1'b0;
        clr_next       = (state != WALK);
      end
      WALK_FLASH: begin
        if (state == WALK_FLASH)
          dont_walk_next = tick ? ~dont_walk_light : dont_walk_light;
      end
      ALL_RED2:    main_next = 3'b100;
      default:     main_next = 3'b001;
    endcase
    // a lit WALK lamp always forces all-red and an unlit DON'T-WALK
    if (walk_next) begin
      main_next      = 3'b100;
      dont_walk_next = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge sys_reset) begin
    if (!sys_reset) begin
      state              <= MAIN_GREEN;
      timer              <= CNT_W'(T_GREEN_MIN - 1);
      main_light         <= 3'b001;
      walk_light         <= 1'b0;
      dont_walk_light    <= 1'b1;
      walkRegister_reset <= 1'b0;
    end else begin
      state              <= state_next;
      timer              <= timer_next;
      main_light         <= main_next;
      walk_light         <= walk_next;
      dont_walk_light    <= dont_walk_next;
      walkRegister_reset <= clr_next;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_crossing_controller.sv
// tb/tb_crossing_controller.sv - self-checking bench for crossing_controller
// Phase/elapsed-tick reference model, per-cycle compare process, directed and random scenarios.
module tb_crossing_controller;
  localparam int TG = 6, TY = 2, TR = 1, TW = 5, TF = 4;

  logic       clk = 1'b0;
  logic       sys_reset = 1'b0;
  logic       tick = 1'b0;
  logic       walkRegister_status = 1'b0;
  logic       walkRegister_reset;
  logic [2:0] main_light;
  logic       walk_light;
  logic       dont_walk_light;
  logic [2:0] state_dbg;

  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  crossing_controller #(
    .T_GREEN_MIN(TG), .T_YELLOW(TY), .T_ALLRED(TR), .T_WALK(TW), .T_FLASH(TF), .CNT_W(4)
  ) dut (
    .clk(clk),
    .sys_reset(sys_reset),
    .tick(tick),
    .walkRegister_status(walkRegister_status),
    .walkRegister_reset(walkRegister_reset),
    .main_light(main_light),
    .walk_light(walk_light),
    .dont_walk_light(dont_walk_light),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: phase index plus ticks elapsed in that phase.
  int dur[6] = '{TG, TY, TR, TW, TF, TR};
  int m_phase = 0;
  int m_elapsed = 0;
  bit m_clr = 1'b0;

  always @(posedge clk or negedge sys_reset) begin : model
    int p, e;
    bit c;
    if (!sys_reset) begin
      p = 0; e = 0; c = 1'b0;
    end else begin
      p = m_phase; e = m_elapsed; c = 1'b0;
      if (tick) begin
        e = e + 1;
        if (e >= dur[p]) begin
          if (p != 0 || walkRegister_status) begin
            p = (p + 1) % 6;
            e = 0;
            c = (p == 3);
          end else begin
            e = dur[0];
          end
        end
      end
    end
    m_phase   <= p;
    m_elapsed <= e;
    m_clr     <= c;
  end

  function automatic logic [2:0] exp_main(input int p);
    if (p == 0) return 3'b001;
    if (p == 1) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic exp_dw(input int p, input int e);
    if (p == 3) return 1'b0;
    if (p == 4) return (e % 2 == 0);
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("state", {5'd0, state_dbg}, 8'(m_phase));
      check("main_light", {5'd0, main_light}, {5'd0, exp_main(m_phase)});
      check("walk_light", {7'd0, walk_light}, {7'd0, 1'(m_phase == 3)});
      check("dont_walk", {7'd0, dont_walk_light}, {7'd0, exp_dw(m_phase, m_elapsed)});
      check("walk_clr", {7'd0, walkRegister_reset}, {7'd0, m_clr});
      check("inv_onehot", {7'd0, 1'($onehot(main_light))}, 8'd1);
      check("inv_walk_red", {7'd0, 1'(walk_light && main_light != 3'b100)}, 8'd0);
      check("inv_lamps", {7'd0, 1'(walk_light && dont_walk_light)}, 8'd0);
    end
  end

  task automatic do_reset();
    @(negedge clk) sys_reset = 1'b0;
    @(negedge clk);
    check("rst_main", {5'd0, main_light}, 8'd1);
    check("rst_dw", {7'd0, dont_walk_light}, 8'd1);
    check("rst_clr", {7'd0, walkRegister_reset}, 8'd0);
    check("rst_state", {5'd0, state_dbg}, 8'd0);
    sys_reset = 1'b1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int max);
    int k = 0;
    while (state_dbg !== s && k < max) begin
      @(negedge clk);
      k++;
    end
    check("wait_state", {5'd0, state_dbg}, {5'd0, s});
  endtask

  int lit_state[20] = '{0,0,0,0,0,0,1,1,2,3,3,3,3,3,4,4,4,4,5,0};
  int lit_dw[4]     = '{1,0,1,0};

  initial begin
    int clr_cnt, cnt_y, cnt_w, cnt_f, cnt_g;
    sys_reset = 1'b0;
    tick = 1'b0;
    walkRegister_status = 1'b0;

    // idle after reset
    do_reset();
    chk_en = 1'b1;
    tick = 1'b1;
    clr_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (walkRegister_reset) clr_cnt++;
    end
    check("idle_clr_count", 8'(clr_cnt), 8'd0);
    check("idle_state", {5'd0, state_dbg}, 8'd0);
    check("idle_model", 8'(m_phase), 8'd0);

    // single request from cycle 0, pinned against literal sequence
    do_reset();
    tick = 1'b1;
    walkRegister_status = 1'b1;
    for (int i = 0; i < 20; i++) begin
      check("seq_state", {5'd0, state_dbg}, 8'(lit_state[i]));
      check("seq_model", 8'(m_phase), 8'(lit_state[i]));
      check("seq_clr", {7'd0, walkRegister_reset}, {7'd0, 1'(i == 9)});
      if (i >= 14 && i <= 17)
        check("seq_flash_dw", {7'd0, dont_walk_light}, 8'(lit_dw[i-14]));
      @(negedge clk);
    end

    // late request: exits green on the first tick after it appears
    do_reset();
    tick = 1'b1;
    walkRegister_status = 1'b0;
    repeat (15) @(negedge clk);
    check("late_green", {5'd0, state_dbg}, 8'd0);
    walkRegister_status = 1'b1;
    @(negedge clk);
    check("late_yellow", {5'd0, state_dbg}, 8'd1);

    // tick every 4th cycle
    do_reset();
    walkRegister_status = 1'b1;
    clr_cnt = 0; cnt_y = 0; cnt_w = 0; cnt_f = 0;
    for (int c = 0; c < 96; c++) begin
      tick = (c % 4 == 3);
      @(negedge clk);
      if (walkRegister_reset) clr_cnt++;
      if (state_dbg == 3'd1) cnt_y++;
      if (state_dbg == 3'd3) cnt_w++;
      if (state_dbg == 3'd4) cnt_f++;
    end
    check("gate_yellow_cycles", 8'(cnt_y), 8'(TY * 4));
    check("gate_walk_cycles", 8'(cnt_w), 8'(TW * 4));
    check("gate_flash_cycles", 8'(cnt_f), 8'(TF * 4));
    check("gate_clr_pulses", 8'(clr_cnt), 8'd1);

    // request re-asserted during flash: full green wait afterwards
    do_reset();
    tick = 1'b1;
    walkRegister_status = 1'b1;
    wait_state(3'd3, 40);
    walkRegister_status = 1'b0;
    wait_state(3'd4, 40);
    walkRegister_status = 1'b1;
    wait_state(3'd0, 40);
    cnt_g = 0;
    while (state_dbg == 3'd0 && cnt_g < 30) begin
      cnt_g++;
      @(negedge clk);
    end
    check("rewalk_green_cycles", 8'(cnt_g), 8'(TG));

    // asynchronous reset in the third WALK cycle
    do_reset();
    tick = 1'b1;
    walkRegister_status = 1'b1;
    wait_state(3'd3, 40);
    repeat (2) @(negedge clk);
    #1 sys_reset = 1'b0;
    #1;
    check("async_main", {5'd0, main_light}, 8'd1);
    check("async_walk", {7'd0, walk_light}, 8'd0);
    check("async_dw", {7'd0, dont_walk_light}, 8'd1);
    check("async_state", {5'd0, state_dbg}, 8'd0);
    @(negedge clk) sys_reset = 1'b1;

    // randomized traffic with occasional mid-cycle resets
    for (int c = 0; c < 3000; c++) begin
      tick = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) == 0)
        walkRegister_status = ~walkRegister_status;
      if ($urandom_range(0, 599) == 0) begin
        #2 sys_reset = 1'b0;
        @(negedge clk) sys_reset = 1'b1;
      end else begin
        @(negedge clk);
      end
    end

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/crossing_controller.md
Name: crossing_controller

Overview:
Pedestrian-crossing sequencer for the traffic controller. It drives the main-road lamps and the pedestrian WALK/DON'T-WALK lamps. It consumes the latched request from the walk register (walkRegister_status) and clears that register (walkRegister_reset) once the request has been served. All timing runs on a one-cycle tick enable from the system prescaler, so the whole controller stays in the single clk domain.

Parameters:
T_GREEN_MIN, 6, minimum main-green duration in ticks (>=1)
T_YELLOW, 2, main-yellow duration in ticks (>=1)
T_ALLRED, 1, all-red clearance duration in ticks, used before and after walk (>=1)
T_WALK, 5, steady WALK duration in ticks (>=1)
T_FLASH, 4, flashing DON'T-WALK duration in ticks (>=1)
CNT_W, 4, timer width; must hold max(T_*)-1

Ports:
clk  input  1  system clock, rising edge
sys_reset  input  1  asynchronous, active-low reset (0 = reset)
tick  input  1  one-cycle timing enable from prescaler
walkRegister_status  input  1  latched pedestrian request from walk register
walkRegister_reset  output  1  one-cycle clear pulse to walk register
main_light  output  3  main-road lamps {red,yellow,green}, one-hot
walk_light  output  1  pedestrian WALK lamp
dont_walk_light  output  1  pedestrian DON'T-WALK lamp
state_dbg  output  3  current state encoding, for debug/LEDs

Behaviour:
- All outputs registered. Reset (sys_reset=0, async) forces:
  - state=MAIN_GREEN, timer=T_GREEN_MIN-1
  - main_light=3'b001, walk_light=0, dont_walk_light=1, walkRegister_reset=0
- States and encodings: MAIN_GREEN=0, MAIN_YELLOW=1, ALL_RED1=2, WALK=3, WALK_FLASH=4, ALL_RED2=5. Codes 6 and 7 are illegal and recover to MAIN_GREEN with reset outputs on the next clk.
- Timer rule:
  - On state entry, timer is loaded with T_state-1.
  - On a cycle with tick=1: if timer!=0, timer decrements; if timer==0, the state's exit condition is evaluated.
  - With tick=0, timer and state hold.
  - Each timed state therefore lasts exactly T_state ticks.
- Transitions (evaluated only on a tick with timer==0):
  - MAIN_GREEN -> MAIN_YELLOW only if walkRegister_status=1. Otherwise it stays in MAIN_GREEN with timer held at 0, so a later request exits on the next tick.
  - MAIN_YELLOW -> ALL_RED1 -> WALK -> WALK_FLASH -> ALL_RED2 -> MAIN_GREEN, unconditionally.
- Lamps per state:
  - MAIN_GREEN: main 001, walk 0, dont_walk 1
  - MAIN_YELLOW: main 010, walk 0, dont_walk 1
  - ALL_RED1 and ALL_RED2: main 100, walk 0, dont_walk 1
  - WALK: main 100, walk 1, dont_walk 0
  - WALK_FLASH: main 100, walk 0; dont_walk is 1 on the entry cycle and toggles on every tick while in the state
- walkRegister_reset:
  - High for exactly one clk, on the clock edge entering WALK (visible during the first cycle of WALK).
  - Never asserted in any other state.
  - A request latched by the walk register after that pulse, during WALK/WALK_FLASH/ALL_RED2, persists and is served in the next cycle, after T_GREEN_MIN.
- Simultaneous events:
  - A request arriving on the same cycle as the qualifying tick in MAIN_GREEN (timer==0) is honoured on that tick.
  - A request in any other state has no effect on sequencing.
- Reset mid-operation: from any state, asynchronous return to the reset values. A pending walkRegister_reset pulse is cancelled.
- Safety invariants, enforced in the RTL and checked by assertions:
  - main_light is always one-hot.
  - walk_light=1 implies main_light=100.
  - walk_light and dont_walk_light are never both 1.

Test Plan:
- Reset/idle: sys_reset low 2 cycles then high, tick every cycle, walkRegister_status=0 for 20 cycles -> main_light=001, dont_walk=1, state_dbg=0, walkRegister_reset never 1.
- Single request: tick every cycle, status=1 from cycle 0 -> GREEN for 6 cycles, YELLOW 2, ALL_RED1 1, WALK 5 with walkRegister_reset=1 on its first cycle only, WALK_FLASH 4 with dont_walk toggling 1,0,1,0, ALL_RED2 1, then back to GREEN.
- Late request: status=0 for 15 ticks then 1 -> MAIN_YELLOW entered on the first tick after the request. Green lasted 15+ ticks; no re-wait of T_GREEN_MIN.
- Tick gating: tick asserted every 4th cycle with a request -> every state duration is exactly T_state×4 cycles. walkRegister_reset is still a 1-cycle pulse.
- Request during walk: status re-asserted during WALK_FLASH after the clear -> the cycle completes, then GREEN holds exactly 6 ticks and the sequence repeats.
- Reset mid-WALK: sys_reset pulsed low in the 3rd WALK cycle -> outputs return to 001/0/1 asynchronously, before the next clk edge. Invariants hold throughout all scenarios.
